// File: rtl/hilo_unit.sv
// hilo_unit: iterative multiply/divide unit that owns the HI/LO registers.
// Issue ops: mult, multu, div, divu, mthi, mtlo. mfhi/mflo are served through
// rd_data, and stall holds the pipeline while an operation is in flight.
// Optional feature macro: HILO_DIV_EN compiles in the divide datapath and div0.
// Without it, div/divu are ignored and div0 reads 0.
module hilo_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rd_en,
    input  logic        rd_hi,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        div0
);

    localparam int unsigned W  = 32;
    localparam int unsigned AW = 2 * W;
    localparam int unsigned CW = 6;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
`ifdef HILO_DIV_EN
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
`endif
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic            neg_res_q, neg_res_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef HILO_DIV_EN
    logic            is_div_q, is_div_d;
    logic            neg_rem_q, neg_rem_d;
    logic            dz_q, dz_d;
    logic            div0_q, div0_d;
    logic [W:0]      div_diff;
    logic [AW-1:0]   div_step;
    logic [W-1:0]    quo_fix;
    logic [W-1:0]    rem_fix;
`endif

    logic            sgn_op;
    logic [W-1:0]    a_abs;
    logic [W-1:0]    b_abs;
    logic [W:0]      mul_sum;
    logic [AW-1:0]   mul_step;
    logic [AW-1:0]   prod_fix;

    // Operand magnitudes for the signed ops
    always_comb begin
        sgn_op = ~op[0];
        a_abs  = (sgn_op && a[W-1]) ? (~a + W'(1)) : a;
        b_abs  = (sgn_op && b[W-1]) ? (~b + W'(1)) : b;
    end

    // One radix-2 iteration of each datapath, plus the sign-fixed results
    always_comb begin
        mul_sum  = {1'b0, acc_q[AW-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : (W+1)'(0));
        mul_step = {mul_sum, acc_q[W-1:1]};
        prod_fix = neg_res_q ? (~acc_q + AW'(1)) : acc_q;
`ifdef HILO_DIV_EN
        // Remainder stays below the divisor, so bit W of the difference is the borrow
        div_diff = acc_q[AW-1:W-1] - {1'b0, opnd_q};
        div_step = div_diff[W] ? {acc_q[AW-2:0], 1'b0}
                               : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
        quo_fix  = neg_res_q ? (~acc_q[W-1:0] + W'(1)) : acc_q[W-1:0];
        rem_fix  = neg_rem_q ? (~acc_q[AW-1:W] + W'(1)) : acc_q[AW-1:W];
`endif
    end

    // Next-state, datapath and HI/LO update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        neg_res_d = neg_res_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
`ifdef HILO_DIV_EN
        is_div_d  = is_div_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        div0_d    = div0_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_d   = S_CALC;
                            cnt_d     = '0;
                            acc_d     = {W'(0), b_abs};
                            opnd_d    = a_abs;
                            neg_res_d = sgn_op & (a[W-1] ^ b[W-1]);
`ifdef HILO_DIV_EN
                            is_div_d  = 1'b0;
                            neg_rem_d = 1'b0;
                            dz_d      = 1'b0;
                            div0_d    = 1'b0;
`endif
                        end
`ifdef HILO_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            state_d   = S_CALC;
                            cnt_d     = '0;
                            acc_d     = {W'(0), a_abs};
                            opnd_d    = b_abs;
                            neg_res_d = sgn_op & (a[W-1] ^ b[W-1]);
                            is_div_d  = 1'b1;
                            neg_rem_d = sgn_op & a[W-1];
                            dz_d      = (b == W'(0));
                            div0_d    = 1'b0;
                        end
`endif
                        OP_MTHI: begin
                            hi_d = a;
`ifdef HILO_DIV_EN
                            div0_d = 1'b0;
`endif
                        end
                        OP_MTLO: begin
                            lo_d = a;
`ifdef HILO_DIV_EN
                            div0_d = 1'b0;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CW'(1);
                acc_d = mul_step;
`ifdef HILO_DIV_EN
                if (is_div_q) begin
                    acc_d = div_step;
                end
`endif
                if (cnt_q == CW'(31)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                hi_d    = prod_fix[AW-1:W];
                lo_d    = prod_fix[W-1:0];
`ifdef HILO_DIV_EN
                if (is_div_q) begin
                    // Divide by zero: remainder path already reproduces a
                    hi_d   = rem_fix;
                    lo_d   = dz_q ? '1 : quo_fix;
                    div0_d = dz_q;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIX);
    end

    // State and datapath registers; reset discards any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef HILO_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            div0_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            neg_res_q <= neg_res_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef HILO_DIV_EN
            is_div_q  <= is_div_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            div0_q    <= div0_d;
`endif
        end
    end

    // Read port and hazard outputs
    always_comb begin
        rd_data = rd_hi ? hi_q : lo_q;
        busy    = busy_q;
        done    = done_q;
        stall   = busy_q & (rd_en | start);
`ifdef HILO_DIV_EN
        div0    = div0_q;
`else
        div0    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: scoreboard bench for hilo_unit. Reads push expected HI/LO
// values into a queue; a monitor pops and compares on every completed read.
module tb_hilo_unit;

`ifdef HILO_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        dz;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_en;
    logic        rd_hi;
    logic [31:0] rd_data;
    logic        busy;
    logic        stall;
    logic        done;
    logic        div0;

    exp_t        exp_q[$];
    int          n_cmp;
    int          n_bad;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_dz;

    hilo_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .rd_en   (rd_en),
        .rd_hi   (rd_hi),
        .rd_data (rd_data),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .div0    (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue an expected read, then present mfhi/mflo for one cycle
    task automatic rd(input bit hi_sel, input string nm);
        exp_t e;
        e.name = nm;
        e.data = hi_sel ? m_hi : m_lo;
        e.dz   = m_dz;
        exp_q.push_back(e);
        rd_en = 1'b1;
        rd_hi = hi_sel;
        step();
        rd_en = 1'b0;
    endtask

    // Issue one op, measure busy/done timing, then read back HI and LO
    task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] aa,
                          input logic [31:0] bb, input bit active,
                          input logic [31:0] e_hi, input logic [31:0] e_lo, input bit e_dz);
        int busy_len;
        int done_cnt;
        int done_at;
        busy_len = 0;
        done_cnt = 0;
        done_at  = 0;
        start = 1'b1;
        op    = o;
        a     = aa;
        b     = bb;
        step();
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) busy_len++;
            if (done) begin
                done_cnt++;
                done_at = k;
            end
            if (!busy) break;
        end
        check({nm, "_busy_len"}, 64'(busy_len), active ? 64'd33 : 64'd0);
        check({nm, "_done_cnt"}, 64'(done_cnt), active ? 64'd1 : 64'd0);
        if (active) check({nm, "_done_at"}, 64'(done_at), 64'd33);
        step();
        if (active) begin
            m_hi = e_hi;
            m_lo = e_lo;
            m_dz = e_dz;
        end
        rd(1'b1, {nm, "_hi"});
        rd(1'b0, {nm, "_lo"});
    endtask

    // Monitor: every read that is not stalled is a presented result
    always @(negedge clk) begin
        if (!reset && rd_en && !stall) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read", 64'(rd_data), 64'hDEAD_0000_0000_0000);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_data"}, 64'(rd_data), 64'(e.data));
                check({e.name, "_div0"}, 64'(div0), 64'(e.dz));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_cnt;
        int release_at;
        exp_t e;
        logic [2:0] rst_op;

        n_cmp = 0;
        n_bad = 0;
        m_hi  = '0;
        m_lo  = '0;
        m_dz  = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        rd_en = 1'b0;
        rd_hi = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_div0", 64'(div0), 64'd0);
        step();
        rd(1'b1, "rst_hi");
        rd(1'b0, "rst_lo");

        // Multiply
        run_op("mult_m2x3", 3'b000, 32'hFFFF_FFFE, 32'd3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_m3xm5", 3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 32'h0000_0000, 32'h0000_000F, 1'b0);

        // Divide (ignored when the divide datapath is not built)
        run_op("div_m7d2", 3'b010, 32'hFFFF_FFF9, 32'd2, DIV_ON, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_7d2", 3'b011, 32'd7, 32'd2, DIV_ON, 32'd1, 32'd3, 1'b0);
        run_op("div_7dm2", 3'b010, 32'd7, 32'hFFFF_FFFE, DIV_ON, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run_op("div_5d0", 3'b010, 32'd5, 32'd0, DIV_ON, 32'd5, 32'hFFFF_FFFF, 1'b1);
        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, DIV_ON, 32'h0, 32'h8000_0000, 1'b0);

        // Reserved op is ignored
        run_op("op110", 3'b110, 32'd9, 32'd9, 1'b0, 32'h0, 32'h0, 1'b0);

        // Read during a multiply stalls until the product lands; late start ignored
        start = 1'b1;
        op    = 3'b000;
        a     = 32'h7FFF_FFFF;
        b     = 32'h8000_0000;
        step();
        start = 1'b0;
        stall_cnt  = 0;
        release_at = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k == 5) begin
                start = 1'b1;
                op    = 3'b001;
                a     = 32'd1;
                b     = 32'd1;
            end
            if (k == 6) start = 1'b0;
            if (k == 10) begin
                m_hi = 32'hC000_0000;
                m_lo = 32'h8000_0000;
                m_dz = 1'b0;
                e.name = "stall_lo";
                e.data = m_lo;
                e.dz   = m_dz;
                exp_q.push_back(e);
                rd_en = 1'b1;
                rd_hi = 1'b0;
            end
            @(negedge clk);
            if (k >= 10 && stall) stall_cnt++;
            if (k >= 10 && !stall) begin
                release_at = k;
                break;
            end
            step();
        end
        step();
        rd_en = 1'b0;
        check("stall_cycles", 64'(stall_cnt), 64'd24);
        check("stall_release", 64'(release_at), 64'd34);
        check("late_start_busy", 64'(busy), 64'd0);
        rd(1'b1, "stall_hi");

        // mthi / mtlo are visible on the next cycle
        start = 1'b1;
        op    = 3'b100;
        a     = 32'h1234_5678;
        step();
        start = 1'b0;
        check("mthi_busy", 64'(busy), 64'd0);
        m_hi = 32'h1234_5678;
        m_dz = 1'b0;
        rd(1'b1, "mthi");
        start = 1'b1;
        op    = 3'b101;
        a     = 32'hCAFE_F00D;
        step();
        start = 1'b0;
        m_lo = 32'hCAFE_F00D;
        rd(1'b0, "mtlo");

        // Reset in cycle 12 of an operation zeroes HI/LO with no done pulse
        rst_op = DIV_ON ? 3'b010 : 3'b000;
        start = 1'b1;
        op    = rst_op;
        a     = 32'd100;
        b     = 32'd7;
        step();
        start = 1'b0;
        repeat (11) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        stall_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) stall_cnt++;
            @(negedge clk);
        end
        check("abort_done_cnt", 64'(stall_cnt), 64'd0);
        step();
        m_hi = '0;
        m_lo = '0;
        m_dz = 1'b0;
        rd(1'b1, "abort_hi");
        rd(1'b0, "abort_lo");

        step();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Multi-cycle multiply/divide unit and owner of the architectural HI/LO registers for the pipelined MIPS core. The execute stage issues mult/multu/div/divu/mthi/mtlo operations. The unit computes iteratively and writes the 64-bit product, or the quotient/remainder pair, into HI/LO. mfhi/mflo reads are served from HI/LO, and the unit raises a stall to the hazard unit whenever a read or a new issue would collide with an operation in flight.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  issue strobe; sampled each rising edge.
- op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 ignored.
- a  in  32  rs operand (dividend / multiplicand / mthi-mtlo source).
- b  in  32  rt operand (divisor / multiplier).
- rd_en  in  1  mfhi/mflo read request.
- rd_hi  in  1  1 selects HI, 0 selects LO.
- rd_data  out  32  combinational mux of HI/LO by rd_hi.
- busy  out  1  high in CALC and FIX.
- stall  out  1  busy & (rd_en | start).
- done  out  1  one-cycle pulse, high during FIX.
- div0  out  1  sticky divide-by-zero flag, cleared by the next accepted start.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1, op in 000..011:
  - Latch |a|, |b| (two's-complement magnitude for signed ops; raw for unsigned).
  - Latch result sign flags, clear count and accumulator, go to CALC.
- IDLE, start=1, op=100/101: HI (or LO) <= a at that edge; remain IDLE; busy stays 0.
- Start while busy is ignored. stall holds the pipeline, so the same instruction re-presents after completion.
- CALC runs 32 iterations, one per cycle, using a 6-bit counter:
  - mult: radix-2 shift-add on the 64-bit accumulator.
  - div: restoring shift-subtract producing a 32-bit quotient and 32-bit remainder.
  - After iteration 32, go to FIX.
- FIX:
  - Apply signs. Product negated if a[31]^b[31] (signed only). Quotient negated if a[31]^b[31]. Remainder takes the sign of a (signed only).
  - Write HI/LO at the FIX→IDLE edge: mult puts the upper 32 bits in HI and the lower 32 in LO; div puts the remainder in HI and the quotient in LO.
- Divide by zero (b==0, div or divu): LO=32'hFFFF_FFFF, HI=a; div0 set. Still takes the full 33 cycles.
- div 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0, no flag.
- rd_data always reflects current HI/LO. During busy, the old value is visible, but stall is asserted when rd_en=1.

## Timing
- Start accepted at edge E0. CALC spans cycles 1–32, FIX is cycle 33, and HI/LO are updated at edge E34. The cycle-34 read returns the new value with stall=0.
- done is high exactly in cycle 33; busy is high in cycles 1–33.
- mthi/mtlo: zero-latency write; the next cycle's read sees the new value.
- Reset values: HI=0, LO=0, state=IDLE, busy=0, stall=0, done=0, div0=0, and rd_data=0 after reset.
- Reset mid-operation aborts at the next edge: the result is discarded and HI/LO are zeroed.
- reset has priority over start on the same edge.

## Configuration
- HILO_DIV_EN defined: divide datapath and div0 logic are compiled in.
- HILO_DIV_EN undefined:
  - op 010/011 behave like 110/111: ignored, busy stays 0, HI/LO unchanged.
  - div0 is tied to 0.
  - Multiply is unaffected.

## Test plan
- mult a=32'hFFFF_FFFE (−2), b=3 → busy cycles 1–33, done in cycle 33; after E34, HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA.
- multu a=b=32'hFFFF_FFFF → HI=32'hFFFF_FFFE, LO=32'h0000_0001.
- div a=−7, b=2 → LO=32'hFFFF_FFFD (−3), HI=32'hFFFF_FFFF (−1). divu a=7, b=2 → LO=3, HI=1.
- div a=5, b=0 → LO=32'hFFFF_FFFF, HI=5, div0=1 until the next start.
- mult in flight plus rd_en=1 in cycle 10 → stall=1 through cycle 33, 0 in cycle 34 with the product on rd_data. A second start in cycle 5 is ignored.
- mthi a=32'h1234_5678 then reset asserted in cycle 12 of a following div → HI=LO=0, busy=0 next cycle, no done pulse.
